piso_serializer_14: RTL and testbench

- 14-bit parallel-in, serial-out transmitter with a separate shift enable.
- It is the sending end of the 14-bit enabled serial-in shift register capture path.
- Accepts one parallel word through a valid/ready load handshake, then drives it MSB-first on a serial line, one bit per enabled clock edge.
- Drives a bit-valid strobe that connects directly to the receiving shift register's enable, so the receiver's q[13:0] equals the loaded word after one frame.

---
 rtl/piso_serializer_14.sv | 89 ++++++++
 tb/tb_piso_serializer_14.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer_14.sv
// Parallel-in, serial-out transmitter. Takes one word through a valid/ready
// load handshake, then shifts it out MSB-first, one bit per enabled clock edge.
// sd_valid is meant to drive the receiving shift register's enable directly.
module piso_serializer_14 #(
  parameter int unsigned WIDTH      = 14,
  parameter logic        IDLE_LEVEL = 1'b0,
  localparam int unsigned CntW      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             sd,
  output logic             sd_valid,
  output logic             busy,
  output logic             done,
  output logic [CntW-1:0]  bits_left
);

  typedef enum logic {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              sd_q, sd_d;
  logic              done_q, done_d;

  // Next-state logic: load in idle, shift on enabled edges while shifting.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_valid) begin
          shreg_d = load_data;
          cnt_d   = CntW'(WIDTH);
          state_d = StShift;
        end
      end
      StShift: begin
        if (enable) begin
          shreg_d = {shreg_q[WIDTH-2:0], IDLE_LEVEL};
          if (cnt_q == CntW'(1)) begin
            cnt_d   = '0;
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // sd is registered, so it mirrors the MSB the shift register will hold next.
    sd_d = (state_d == StShift) ? shreg_d[WIDTH-1] : IDLE_LEVEL;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
      sd_q    <= IDLE_LEVEL;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      sd_q    <= sd_d;
      done_q  <= done_d;
    end
  end

  // Outputs; load_ready is held low while reset is asserted.
  always_comb begin
    busy       = (state_q == StShift);
    load_ready = (state_q == StIdle) && resetn;
    sd_valid   = busy && enable;
    sd         = sd_q;
    done       = done_q;
    bits_left  = cnt_q;
  end

endmodule

// File: tb/tb_piso_serializer_14.sv
// Directed bench for piso_serializer_14 with a paired 14-bit receiver model.
module tb_piso_serializer_14;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        load_valid;
  logic        load_ready;
  logic [13:0] load_data;
  logic        sd;
  logic        sd_valid;
  logic        busy;
  logic        done;
  logic [3:0]  bits_left;

  logic [13:0] rx_q = '0;
  int          n_cmp = 0;
  int          n_bad = 0;

  piso_serializer_14 dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .sd         (sd),
    .sd_valid   (sd_valid),
    .busy       (busy),
    .done       (done),
    .bits_left  (bits_left)
  );

  always #5 clk = ~clk;

  // Receiver: enabled serial-in shift register fed by sd / sd_valid.
  always @(posedge clk) if (sd_valid) rx_q <= {rx_q[12:0], sd};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Loads w with enable high throughout; optionally pokes a second word mid-frame.
  task automatic send_frame(input logic [13:0] w, input bit poke);
    load_data  = w;
    load_valid = 1'b1;
    enable     = 1'b1;
    tick();
    load_valid = poke;
    if (poke) load_data = 14'h1555;
    chk("load_bits_left", 32'(bits_left), 32'd14);
    for (int i = 0; i < 14; i++) begin
      chk("frame_sd", 32'(sd), 32'(w[13-i]));
      chk("frame_sd_valid", 32'(sd_valid), 32'd1);
      chk("frame_busy", 32'(busy), 32'd1);
      chk("frame_load_ready", 32'(load_ready), 32'd0);
      chk("frame_done_low", 32'(done), 32'd0);
      if (i == 13) load_valid = 1'b0;
      tick();
    end
    chk("frame_done", 32'(done), 32'd1);
    chk("frame_idle", 32'(busy), 32'd0);
    chk("frame_bits_left0", 32'(bits_left), 32'd0);
    chk("frame_rx", 32'(rx_q), 32'(w));
    tick();
    chk("frame_done_once", 32'(done), 32'd0);
    chk("frame_rx_hold", 32'(rx_q), 32'(w));
  endtask

  initial begin
    int   exp_bl;
    int   nval;
    logic prev_sd;
    logic prev_en;

    resetn = 1'b0; enable = 1'b0; load_valid = 1'b0; load_data = '0;
    #3;
    chk("rst_sd", 32'(sd), 32'd0);
    chk("rst_sd_valid", 32'(sd_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bits_left", 32'(bits_left), 32'd0);
    tick(); tick();
    resetn = 1'b1;
    tick();
    chk("idle_load_ready", 32'(load_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      enable = ~enable;
      tick();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_sd_valid", 32'(sd_valid), 32'd0);
      chk("idle_sd", 32'(sd), 32'd0);
      chk("idle_bits_left", 32'(bits_left), 32'd0);
    end

    // Single frame, enable held high.
    send_frame(14'h2A5B, 1'b0);

    // Busy rejection: 14'h1555 offered during the frame must never be sent.
    send_frame(14'h0001, 1'b1);
    chk("reject_still_idle", 32'(busy), 32'd0);

    // Gapped enable with all-ones word.
    load_data = 14'h3FFF; load_valid = 1'b1; enable = 1'b1;
    tick();
    load_valid = 1'b0;
    exp_bl = 14; nval = 0;
    for (int k = 0; k < 60 && busy; k++) begin
      enable = (k % 2 == 0);
      chk("gap_bits_left", 32'(bits_left), 32'(exp_bl));
      if (sd_valid) begin
        nval++;
        chk("gap_sd_one", 32'(sd), 32'd1);
      end
      prev_sd = sd;
      prev_en = enable;
      tick();
      if (prev_en) exp_bl--;
      else chk("gap_sd_hold", 32'(sd), 32'(prev_sd));
    end
    chk("gap_valid_count", 32'(nval), 32'd14);
    chk("gap_done", 32'(done), 32'd1);
    chk("gap_bits_left0", 32'(bits_left), 32'd0);
    chk("gap_rx", 32'(rx_q), 32'h3FFF);
    enable = 1'b1;
    tick();

    // Back-to-back: second word accepted in the done cycle.
    load_data = 14'h1234; load_valid = 1'b1;
    tick();
    load_data = 14'h0ABC;
    for (int i = 0; i < 14; i++) begin
      chk("b2b_first_sd", 32'(sd), 32'(14'h1234 >> (13 - i)) & 32'd1);
      tick();
    end
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_ready", 32'(load_ready), 32'd1);
    chk("b2b_rx_first", 32'(rx_q), 32'h1234);
    tick();
    load_valid = 1'b0;
    chk("b2b_second_busy", 32'(busy), 32'd1);
    chk("b2b_second_bits_left", 32'(bits_left), 32'd14);
    for (int i = 0; i < 14; i++) begin
      chk("b2b_second_sd", 32'(sd), 32'(14'h0ABC >> (13 - i)) & 32'd1);
      tick();
    end
    chk("b2b_done2", 32'(done), 32'd1);
    chk("b2b_rx_second", 32'(rx_q), 32'h0ABC);
    tick();

    // Mid-frame reset after five enabled bits.
    load_data = 14'h2A5B; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    repeat (5) tick();
    chk("mid_bits_left", 32'(bits_left), 32'd9);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_sd", 32'(sd), 32'd0);
    chk("mid_rst_sd_valid", 32'(sd_valid), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_bits_left", 32'(bits_left), 32'd0);
    tick(); tick();
    chk("mid_rst_no_done", 32'(done), 32'd0);
    resetn = 1'b1;
    tick();
    chk("mid_rel_ready", 32'(load_ready), 32'd1);
    chk("mid_rel_busy", 32'(busy), 32'd0);
    chk("mid_rel_no_done", 32'(done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
